// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_buffer
//  Description : Instruction queue between fetch and decode. It is a
//                first-word-fall-through circular FIFO. Each entry holds
//                {fetch_adel, fetch_pc, fetch_inst}. An entry pushed at one
//                clock edge is presented to decode right after that edge.
//                The head outputs are zeroed (a NOP) while the queue is
//                empty. A flush discards everything, including a push in the
//                same cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1        clock, rising-edge active
//    rst          in   1        asynchronous active-high reset
//    flush        in   1        discard all queued instructions
//    fetch_valid  in   1        fetch presents an instruction
//    fetch_ready  out  1        queue can accept a push (not full)
//    fetch_inst   in   32       fetched instruction word
//    fetch_pc     in   32       PC of fetch_inst
//    fetch_adel   in   1        fetch address error flag
//    dec_ready    in   1        decode consumes the head this cycle
//    dec_valid    out  1        head entry is valid
//    instrD       out  32       head instruction (0 when empty)
//    pcD          out  32       head PC (0 when empty)
//    adelD        out  1        head address error flag (0 when empty)
//    countD       out  PTR_W+1  occupancy, 0..DEPTH
// ============================================================================
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_inst,
    input  logic [31:0]      fetch_pc,
    input  logic             fetch_adel,
    input  logic             dec_ready,
    output logic             dec_valid,
    output logic [31:0]      instrD,
    output logic [31:0]      pcD,
    output logic             adelD,
    output logic [PTR_W:0]   countD
);

    localparam int             C_ENTRY_W = 65;
    localparam logic [PTR_W:0] C_FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] C_ONE_CNT = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] C_ONE_PTR = PTR_W'(1);

    // Storage is deliberately left out of reset; count alone decides
    // which entries are visible.
    logic [C_ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic             push_w;
    logic             pop_w;
    logic             full_w;
    logic             empty_w;
    logic [C_ENTRY_W-1:0] head_w;

    // Status comes only from registered state. A pop in the same cycle
    // therefore never opens room for a push into a full queue.
    assign full_w      = (count_q == C_FULL);
    assign empty_w     = (count_q == '0);
    assign fetch_ready = ~full_w;
    assign dec_valid   = ~empty_w;

    assign push_w = fetch_valid & ~full_w;
    assign pop_w  = dec_ready   & ~empty_w;

    // ------------------------------------------------------------------
    // Next-state computation for the pointers and the occupancy count
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + C_ONE_PTR;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + C_ONE_PTR;
            end
            // A simultaneous push and pop leaves the count unchanged.
            unique case ({push_w, pop_w})
                2'b10:   count_d = count_q + C_ONE_CNT;
                2'b01:   count_d = count_q - C_ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage write. A write during flush is suppressed. It would be
    // invisible anyway, but skipping it keeps the array contents tidy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_w && !flush) begin
            mem_q[wr_ptr_q] <= {fetch_adel, fetch_pc, fetch_inst};
        end
    end

    // ------------------------------------------------------------------
    // Fall-through head read. It is masked to zero when empty, so decode
    // sees SLL $0 (a NOP) with a clean PC and error flag.
    // ------------------------------------------------------------------
    always_comb begin
        head_w = '0;
        if (!empty_w) begin
            head_w = mem_q[rd_ptr_q];
        end
    end

    assign instrD = head_w[31:0];
    assign pcD    = head_w[63:32];
    assign adelD  = head_w[64];
    assign countD = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_buffer
//  Description : Self-checking bench for inst_buffer. Directed scenarios run
//                first, then randomized traffic. A queue-based reference
//                model holds the expected contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [31:0]      fetch_inst;
    logic [31:0]      fetch_pc;
    logic             fetch_adel;
    logic             dec_ready;
    logic             dec_valid;
    logic [31:0]      instrD;
    logic [31:0]      pcD;
    logic             adelD;
    logic [PTR_W:0]   countD;

    int total = 0;
    int bad   = 0;

    // Reference model: contents in push order, entry = {adel, pc, inst}.
    logic [64:0] model_q[$];

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_adel  (fetch_adel),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .instrD      (instrD),
        .pcD         (pcD),
        .adelD       (adelD),
        .countD      (countD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the head.
    task automatic check_model();
        logic [64:0] h;
        logic        v;
        v = (model_q.size() != 0);
        h = v ? model_q[0] : 65'h0;
        chk("dec_valid",   64'(dec_valid),   64'(v));
        chk("instrD",      64'(instrD),      64'(h[31:0]));
        chk("pcD",         64'(pcD),         64'(h[63:32]));
        chk("adelD",       64'(adelD),       64'(h[64]));
        chk("countD",      64'(countD),      64'(model_q.size()));
        chk("fetch_ready", 64'(fetch_ready), 64'(model_q.size() != DEPTH));
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cyc(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic adel, input logic dr, input logic fl);
        logic do_push;
        logic do_pop;
        fetch_valid = fv;
        fetch_inst  = inst;
        fetch_pc    = pc;
        fetch_adel  = adel;
        dec_ready   = dr;
        flush       = fl;
        #1;
        check_model();
        do_pop  = dr && (model_q.size() != 0);
        do_push = fv && (model_q.size() != DEPTH);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({adel, pc, inst});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, dr, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_inst  = '0;
        fetch_pc    = '0;
        fetch_adel  = 1'b0;
        dec_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        // Reset state
        chk("rst_dec_valid",   64'(dec_valid),   64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk("rst_countD",      64'(countD),      64'd0);
        chk("rst_instrD",      64'(instrD),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single pass with one-cycle fetch-to-decode latency
        cyc(1'b1, 32'h24080005, 32'hBFC00000, 1'b0, 1'b1, 1'b0);
        #1;
        chk("single_valid", 64'(dec_valid), 64'd1);
        chk("single_inst",  64'(instrD),    64'h24080005);
        chk("single_pc",    64'(pcD),       64'hBFC00000);
        idle(1'b1);
        #1;
        chk("single_empty_valid", 64'(dec_valid), 64'd0);
        chk("single_empty_inst",  64'(instrD),    64'd0);

        // Fill and stall: the 9th push is rejected
        for (int i = 0; i < 9; i++)
            cyc(1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_count", 64'(countD),      64'd8);
        chk("fill_ready", 64'(fetch_ready), 64'd0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_pc", 64'(pcD), 64'(32'h100 + 32'(4 * i)));
            idle(1'b1);
        end
        #1;
        chk("drain_empty", 64'(dec_valid), 64'd0);

        // Full with simultaneous pop: push rejected, then push+pop together
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'hB000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB000_0008, 32'h320, 1'b0, 1'b1, 1'b0);
        #1;
        chk("fullpop_count7", 64'(countD), 64'd7);
        cyc(1'b1, 32'hB000_0009, 32'h324, 1'b0, 1'b1, 1'b0);
        #1;
        chk("pushpop_count7", 64'(countD), 64'd7);
        for (int i = 0; i < 7; i++) idle(1'b1);

        // Wrap-around at steady occupancy of 3
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'hC000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("wrap_pc", 64'(pcD), 64'(32'h400 + 32'(4 * i)));
            cyc(1'b1, 32'hC000_0000 + 32'(i + 3), 32'h400 + 32'(4 * (i + 3)), 1'b0, 1'b1, 1'b0);
        end
        #1;
        chk("wrap_count", 64'(countD), 64'd3);

        // Flush with a same-cycle push
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'hD000_0000 + 32'(i), 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_BEEF, 32'h5FC, 1'b0, 1'b0, 1'b1);
        #1;
        chk("flush_count", 64'(countD),    64'd0);
        chk("flush_valid", 64'(dec_valid), 64'd0);
        chk("flush_inst",  64'(instrD),    64'd0);
        cyc(1'b1, 32'h1234_5678, 32'h600, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_head_pc", 64'(pcD), 64'h600);
        idle(1'b1);

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'hE000_0000 + 32'(i), 32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        fetch_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(dec_valid),   64'd0);
        chk("arst_count", 64'(countD),      64'd0);
        chk("arst_ready", 64'(fetch_ready), 64'd1);
        chk("arst_pc",    64'(pcD),         64'd0);
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 32'h0000_000C, 32'h800, 1'b1, 1'b0, 1'b0);
        #1;
        chk("arst_adel", 64'(adelD), 64'd1);
        chk("arst_first_pc", 64'(pcD), 64'h800);
        idle(1'b1);

        // Randomized traffic; consume probability varies by phase so the
        // queue visits empty, full and middle occupancies.
        for (int i = 0; i < 600; i++) begin
            logic dr;
            int   phase;
            phase = (i / 100) % 3;
            case (phase)
                0:       dr = ($urandom_range(0, 3) == 0);
                1:       dr = ($urandom_range(0, 3) != 0);
                default: dr = $urandom_range(0, 1) == 1;
            endcase
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                dr, 1'($urandom_range(0, 29) == 0));
        end
        #1;
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
